// File: rtl/ram_loader_arbiter_if.sv
// Byte-stream handshake between the program loader (master) and the RAM arbiter (slave).
interface ram_loader_arbiter_if #(
    parameter int DW = 8
);
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;

    modport master (output ld_valid, ld_data, ld_last, input ld_ready);
    modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/ram_loader_arbiter.sv
// Owns the single program-RAM port: passes CPU traffic through when idle, otherwise halts
// the CPU and streams loader bytes into RAM from address 0 upward.
module ram_loader_arbiter #(
    parameter int DW          = 8,
    parameter int AW          = 4,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start_i,
    ram_loader_arbiter_if.slave    ld,
    input  logic [AW-1:0]          cpu_addr_i,
    input  logic [DW-1:0]          cpu_data_i,
    input  logic                   cpu_rw_i,
    input  logic                   cpu_ro_i,
    output logic                   cpu_halt_o,
    output logic [AW-1:0]          ram_addr_o,
    output logic [DW-1:0]          ram_data_in_o,
    output logic                   ram_rw_o,
    output logic                   ram_ro_o,
    output logic                   load_done_o,
    output logic [AW:0]            load_count_o
);

    localparam int HCW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        LOAD,
        FLUSH,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [HCW-1:0] halt_cnt_q, halt_cnt_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [DW-1:0]  wr_data_q, wr_data_d;
    logic           wr_en_q, wr_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            halt_cnt_q <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_cnt_q <= halt_cnt_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        halt_cnt_d = halt_cnt_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = wr_en_q;
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d    = HALT;
                    halt_cnt_d = '0;
                    ptr_d      = '0;
                    count_d    = '0;
                    wr_en_d    = 1'b0;
                end
            end
            HALT: begin
                ptr_d = '0;
                if (halt_cnt_q == HCW'(HALT_CYCLES - 1)) begin
                    state_d = LOAD;
                end else begin
                    halt_cnt_d = halt_cnt_q + HCW'(1);
                end
            end
            LOAD: begin
                // The last RAM word ends the load even without ld_last, so ptr never wraps onto address 0.
                if (ld.ld_valid) begin
                    wr_addr_d = ptr_q;
                    wr_data_d = ld.ld_data;
                    wr_en_d   = 1'b1;
                    ptr_d     = ptr_q + AW'(1);
                    count_d   = count_q + (AW+1)'(1);
                    if (ld.ld_last || (ptr_q == AW'(DEPTH - 1))) begin
                        state_d = FLUSH;
                    end
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            FLUSH: begin
                wr_en_d = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ld.ld_ready  = (state_q == LOAD) && !rst;
        load_done_o  = (state_q == DONE) && !rst;
        cpu_halt_o   = (state_q != IDLE);
        load_count_o = count_q;
        if (state_q == IDLE) begin
            ram_addr_o    = cpu_addr_i;
            ram_data_in_o = cpu_data_i;
            ram_rw_o      = cpu_rw_i;
            ram_ro_o      = cpu_ro_i;
        end else begin
            ram_addr_o    = wr_addr_q;
            ram_data_in_o = wr_data_q;
            ram_rw_o      = ~wr_en_q;
            ram_ro_o      = 1'b0;
        end
        // The RAM writes on any edge with RW low, so reset must pull it high without waiting for the registers.
        if (rst) begin
            ram_rw_o = 1'b1;
            ram_ro_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_loader_arbiter.sv
// Directed bench for ram_loader_arbiter with a behavioural 16x8 RAM that writes on RW=0 edges.
module tb_ram_loader_arbiter;

    logic       clk;
    logic       rst;
    logic       loadStart;
    logic [3:0] cpuAddr;
    logic [7:0] cpuData;
    logic       cpuRw;
    logic       cpuRo;
    logic       cpuHalt;
    logic [3:0] ramAddr;
    logic [7:0] ramDataIn;
    logic       ramRw;
    logic       ramRo;
    logic       loadDone;
    logic [4:0] loadCount;

    logic [7:0] mem [16];
    logic       preloadReq;
    int         writeCount;
    int         wcBefore;
    int         testsRun;
    int         testsFailed;

    ram_loader_arbiter_if #(.DW(8)) ldIf ();

    ram_loader_arbiter #(
        .DW(8), .AW(4), .DEPTH(16), .HALT_CYCLES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start_i  (loadStart),
        .ld            (ldIf.slave),
        .cpu_addr_i    (cpuAddr),
        .cpu_data_i    (cpuData),
        .cpu_rw_i      (cpuRw),
        .cpu_ro_i      (cpuRo),
        .cpu_halt_o    (cpuHalt),
        .ram_addr_o    (ramAddr),
        .ram_data_in_o (ramDataIn),
        .ram_rw_o      (ramRw),
        .ram_ro_o      (ramRo),
        .load_done_o   (loadDone),
        .load_count_o  (loadCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: preload fills every word with 0x77, otherwise write on every edge with RW low.
    always @(posedge clk) begin
        if (preloadReq) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h77;
        end else if (ramRw === 1'b0) begin
            mem[ramAddr] <= ramDataIn;
            writeCount   <= writeCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preloadRam();
        @(negedge clk);
        preloadReq = 1'b1;
        @(negedge clk);
        preloadReq = 1'b0;
    endtask

    // Starts a load from IDLE and returns in the first LOAD cycle, checking the halt window length.
    task automatic applyStimulus();
        @(negedge clk);
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        #1;
        checkOutput("haltCpuHalt", cpuHalt, 1);
        checkOutput("halt1Ready", ldIf.ld_ready, 0);
        @(negedge clk);
        #1;
        checkOutput("halt2Ready", ldIf.ld_ready, 0);
        checkOutput("haltRw", ramRw, 1);
        @(negedge clk);
        #1;
        checkOutput("loadReady", ldIf.ld_ready, 1);
    endtask

    // Drives one valid byte in the current cycle and advances to the next negedge.
    task automatic sendByte(input logic [7:0] d, input logic last);
        ldIf.ld_valid = 1'b1;
        ldIf.ld_data  = d;
        ldIf.ld_last  = last;
        #1;
        checkOutput("sendReady", ldIf.ld_ready, 1);
        @(negedge clk);
        ldIf.ld_valid = 1'b0;
        ldIf.ld_last  = 1'b0;
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        writeCount = 0;
        preloadReq = 1'b0;
        loadStart = 1'b0;
        ldIf.ld_valid = 1'b0;
        ldIf.ld_data = 8'h00;
        ldIf.ld_last = 1'b0;
        cpuAddr = 4'h0;
        cpuData = 8'h00;

        // Reset overrides a CPU write request combinationally.
        rst = 1'b1;
        cpuRw = 1'b0;
        cpuRo = 1'b1;
        #1;
        checkOutput("rstRamRw", ramRw, 1);
        checkOutput("rstRamRo", ramRo, 0);
        checkOutput("rstReady", ldIf.ld_ready, 0);
        checkOutput("rstDone", loadDone, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cpuRw = 1'b1;
        cpuRo = 1'b0;
        #1;
        checkOutput("postRstHalt", cpuHalt, 0);
        checkOutput("postRstReady", ldIf.ld_ready, 0);
        checkOutput("postRstCount", loadCount, 0);

        // Full 16-byte load terminated by the last address.
        wcBefore = writeCount;
        applyStimulus();
        for (int i = 0; i < 16; i++) sendByte(8'h10 + 8'(i), 1'b0);
        #1;
        checkOutput("fullFlushRw", ramRw, 0);
        checkOutput("fullFlushAddr", ramAddr, 15);
        checkOutput("fullFlushData", ramDataIn, 8'h1F);
        checkOutput("fullFlushReady", ldIf.ld_ready, 0);
        checkOutput("fullFlushDone", loadDone, 0);
        @(negedge clk);
        #1;
        checkOutput("fullDone", loadDone, 1);
        checkOutput("fullDoneHalt", cpuHalt, 1);
        checkOutput("fullCount", loadCount, 16);
        @(negedge clk);
        #1;
        checkOutput("fullDoneDrop", loadDone, 0);
        checkOutput("fullIdleHalt", cpuHalt, 0);
        checkOutput("fullWrites", writeCount - wcBefore, 16);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("fullMem%0d", i), mem[i], 8'h10 + 8'(i));
        cpuAddr = 4'd5;
        cpuRo = 1'b1;
        #1;
        checkOutput("readAddr", ramAddr, 5);
        checkOutput("readRo", ramRo, 1);
        checkOutput("readData", mem[ramAddr], 8'h15);
        cpuRo = 1'b0;

        // Short load ending on ld_last; word 3 keeps its preload.
        preloadRam();
        wcBefore = writeCount;
        applyStimulus();
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b0);
        sendByte(8'hCC, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("shortDone", loadDone, 1);
        checkOutput("shortCount", loadCount, 3);
        @(negedge clk);
        checkOutput("shortMem0", mem[0], 8'hAA);
        checkOutput("shortMem1", mem[1], 8'hBB);
        checkOutput("shortMem2", mem[2], 8'hCC);
        checkOutput("shortMem3", mem[3], 8'h77);
        checkOutput("shortWrites", writeCount - wcBefore, 3);

        // Valid pattern 1,0,0,1: writes only after accepts, contiguous addresses.
        applyStimulus();
        sendByte(8'h31, 1'b0);
        #1;
        checkOutput("gapWr0Rw", ramRw, 0);
        checkOutput("gapWr0Addr", ramAddr, 0);
        checkOutput("gapWr0Data", ramDataIn, 8'h31);
        @(negedge clk);
        #1;
        checkOutput("gapIdleRw", ramRw, 1);
        @(negedge clk);
        #1;
        checkOutput("gapIdle2Rw", ramRw, 1);
        sendByte(8'h32, 1'b1);
        #1;
        checkOutput("gapWr1Rw", ramRw, 0);
        checkOutput("gapWr1Addr", ramAddr, 1);
        checkOutput("gapWr1Data", ramDataIn, 8'h32);
        @(negedge clk);
        #1;
        checkOutput("gapDone", loadDone, 1);
        checkOutput("gapCount", loadCount, 2);
        @(negedge clk);

        // load_start inside LOAD is ignored; reset mid-load stops writes but keeps written bytes.
        preloadRam();
        applyStimulus();
        sendByte(8'h50, 1'b0);
        loadStart = 1'b1;
        sendByte(8'h51, 1'b0);
        sendByte(8'h52, 1'b0);
        loadStart = 1'b0;
        sendByte(8'h53, 1'b0);
        sendByte(8'h54, 1'b0);
        #1;
        checkOutput("midWr4Rw", ramRw, 0);
        checkOutput("midWr4Addr", ramAddr, 4);
        @(negedge clk);
        rst = 1'b1;
        ldIf.ld_valid = 1'b1;
        ldIf.ld_data = 8'h99;
        #1;
        checkOutput("midRstRw", ramRw, 1);
        checkOutput("midRstReady", ldIf.ld_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        ldIf.ld_valid = 1'b0;
        #1;
        checkOutput("midRstHalt", cpuHalt, 0);
        checkOutput("midRstCount", loadCount, 0);
        checkOutput("midRstIdleReady", ldIf.ld_ready, 0);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("midMem%0d", i), mem[i], 8'h50 + 8'(i));
        checkOutput("midMem5", mem[5], 8'h77);

        // IDLE passthrough, then CPU write requests are blocked while halted.
        cpuAddr = 4'd7;
        cpuData = 8'hEE;
        cpuRw = 1'b1;
        cpuRo = 1'b1;
        #1;
        checkOutput("passAddr", ramAddr, 7);
        checkOutput("passRw", ramRw, 1);
        checkOutput("passRo", ramRo, 1);
        @(negedge clk);
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        cpuRw = 1'b0;
        wcBefore = writeCount;
        #1;
        checkOutput("haltCpuRw", ramRw, 1);
        checkOutput("haltCpuRo", ramRo, 0);
        @(negedge clk);
        #1;
        checkOutput("haltCpuRw2", ramRw, 1);
        @(negedge clk);
        checkOutput("haltNoWrite", writeCount - wcBefore, 0);
        checkOutput("haltMem7", mem[7], 8'h77);
        cpuRw = 1'b1;
        cpuRo = 1'b0;
        sendByte(8'h61, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("lastDone", loadDone, 1);
        checkOutput("lastCount", loadCount, 1);
        @(negedge clk);
        checkOutput("lastMem0", mem[0], 8'h61);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
